blake2_digest_streamer: RTL

// - Downstream of the Blake2 input controller and hash core. Captures the finished digest on

---
 rtl/blake2_digest_streamer.sv | 117 +++++++++++
 1 files changed

// File: rtl/blake2_digest_streamer.sv
// rtl/blake2_digest_streamer.sv - captures a finished Blake2 digest and streams it out BUS_WIDTH bits per beat
// Optional build macro: DIGEST_BYTESWAP_EN (byte-reverse each output word).
module blake2_digest_streamer #(
   parameter int BUS_WIDTH    = 32,
   parameter int DIGEST_WIDTH = 512
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    digest_valid,
   input  logic [DIGEST_WIDTH-1:0] digest,
   input  logic [6:0]              out_len,
   output logic [BUS_WIDTH-1:0]    dout,
   output logic                    dout_valid,
   input  logic                    dout_ready,
   output logic                    dout_last,
   output logic                    busy,
   output logic                    overrun
);

   localparam int BB     = BUS_WIDTH / 8;
   localparam int NWORDS = DIGEST_WIDTH / BUS_WIDTH;
   localparam int DBYTES = DIGEST_WIDTH / 8;
   localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   typedef enum logic [0:0] {IDLE, STREAM} state_t;

   state_t                  state;
   logic [DIGEST_WIDTH-1:0] shadow;
   logic [7:0]              len_q;
   logic [IDX_W-1:0]        idx;
   logic [IDX_W-1:0]        last_idx;
   logic                    dv_q;

   logic                    dv_rise;
   logic [7:0]              len_in;
   logic [IDX_W-1:0]        last_idx_in;
   logic [IDX_W-1:0]        next_idx;

   // Bytes at or beyond the requested length read as zero; ordering within the word is build-selected.
   function automatic logic [BUS_WIDTH-1:0] word_at(input logic [DIGEST_WIDTH-1:0] src,
                                                    input logic [IDX_W-1:0]        w,
                                                    input logic [7:0]              len);
      logic [BUS_WIDTH-1:0] raw;
      logic [BUS_WIDTH-1:0] res;
      raw = src[int'(w)*BUS_WIDTH +: BUS_WIDTH];
      res = '0;
      for (int j = 0; j < BB; j++) begin
         if (int'(w) * BB + j < int'(len)) begin
`ifdef DIGEST_BYTESWAP_EN
            res[(BB-1-j)*8 +: 8] = raw[j*8 +: 8];
`else
            res[j*8 +: 8] = raw[j*8 +: 8];
`endif
         end
      end
      return res;
   endfunction

   always_comb begin
      dv_rise     = digest_valid & ~dv_q;
      len_in      = ((out_len == 7'd0) || ({1'b0, out_len} > 8'(DBYTES))) ? 8'(DBYTES) : {1'b0, out_len};
      last_idx_in = IDX_W'((int'(len_in) - 1) / BB);
      next_idx    = idx + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         shadow     <= '0;
         len_q      <= '0;
         idx        <= '0;
         last_idx   <= '0;
         dv_q       <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         dv_q <= digest_valid;
         case (state)
            IDLE: begin
               if (dv_rise) begin
                  shadow     <= digest;
                  len_q      <= len_in;
                  last_idx   <= last_idx_in;
                  idx        <= '0;
                  overrun    <= 1'b0;
                  dout       <= word_at(digest, '0, len_in);
                  dout_valid <= 1'b1;
                  dout_last  <= (last_idx_in == '0);
                  busy       <= 1'b1;
                  state      <= STREAM;
               end
            end
            STREAM: begin
               // A digest arriving mid-stream is dropped, only the sticky flag records it.
               if (dv_rise) overrun <= 1'b1;
               if (dout_valid && dout_ready) begin
                  if (dout_last) begin
                     dout_valid <= 1'b0;
                     dout_last  <= 1'b0;
                     busy       <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     idx       <= next_idx;
                     dout      <= word_at(shadow, next_idx, len_q);
                     dout_last <= (next_idx == last_idx);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
